// File: rtl/router_sched_pkg.sv
// Shared types and constants for the router output scheduler.
package router_sched_pkg;

    localparam int unsigned N_PORTS = 4;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sched_state_e;

    // prio[i][j] == 1 means port i currently takes precedence over port j.
    typedef logic [N_PORTS-1:0][N_PORTS-1:0] prio_mat_t;

    localparam prio_mat_t PRIO_INIT = {4'b0000, 4'b1000, 4'b1100, 4'b1110};

    function automatic logic [IDX_W-1:0] oh2idx(input logic [N_PORTS-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/router_output_scheduler_if.sv
// Flit request/grant and credit signals between input ports and the output scheduler.
interface router_output_scheduler_if
    import router_sched_pkg::*;
#(
    parameter int unsigned CW = 3
);
    logic [N_PORTS-1:0] request;
    logic [N_PORTS-1:0] head;
    logic [N_PORTS-1:0] tail;
    logic               credit_in;
    logic [N_PORTS-1:0] grant;
    logic               forward;
    logic               locked;
    logic [CW-1:0]      credits;

    modport master (
        output request, head, tail, credit_in,
        input  grant, forward, locked, credits
    );

    modport slave (
        input  request, head, tail, credit_in,
        output grant, forward, locked, credits
    );
endinterface

// File: rtl/router_rr_matrix.sv
// Precedence-matrix round-robin arbiter: combinational winner, winner demoted to lowest on update.
module router_rr_matrix
    import router_sched_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req_i,
    input  logic               upd_i,
    output logic [N_PORTS-1:0] win_o
);
    prio_mat_t prio_q, prio_d;

    // A requester wins when it beats every other active requester.
    always_comb begin
        win_o = '0;
        for (int i = 0; i < int'(N_PORTS); i++) begin
            logic beats;
            beats = 1'b1;
            for (int j = 0; j < int'(N_PORTS); j++) begin
                if (j != i && req_i[j] && !prio_q[i][j]) beats = 1'b0;
            end
            win_o[i] = req_i[i] & beats;
        end
    end

    always_comb begin
        prio_d = prio_q;
        if (upd_i) begin
            for (int i = 0; i < int'(N_PORTS); i++) begin
                if (win_o[i]) begin
                    for (int j = 0; j < int'(N_PORTS); j++) begin
                        prio_d[i][j] = 1'b0;
                        prio_d[j][i] = 1'(j != i);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) prio_q <= PRIO_INIT;
        else     prio_q <= prio_d;
    end
endmodule

// File: rtl/router_output_scheduler.sv
// Output-port scheduler: packet-locking wormhole FSM, round-robin head arbitration, credit flow control.
module router_output_scheduler
    import router_sched_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
)(
    input  logic                    clk,
    input  logic                    rst,
    router_output_scheduler_if.slave bus
);
    sched_state_e       state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [CW-1:0]      credits_q, credits_d;
    logic [N_PORTS-1:0] eligible, rr_win, grant_c;
    logic               has_credit, fwd_c, upd_prio_c;

    assign eligible   = bus.request & bus.head;
    assign has_credit = (credits_q != '0);

    router_rr_matrix u_rr (
        .clk   (clk),
        .rst   (rst),
        .req_i (eligible),
        .upd_i (upd_prio_c),
        .win_o (rr_win)
    );

    // Grant is zero-latency; the owner keeps the output until its tail is forwarded.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        grant_c    = '0;
        upd_prio_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (has_credit && (|rr_win)) begin
                    grant_c    = rr_win;
                    upd_prio_c = 1'b1;
                    if (!(|(rr_win & bus.tail))) begin
                        state_d = LOCKED;
                        owner_d = oh2idx(rr_win);
                    end
                end
            end
            LOCKED: begin
                if (has_credit && bus.request[owner_q]) begin
                    grant_c = N_PORTS'(1) << owner_q;
                    if (bus.tail[owner_q]) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (rst) begin
            grant_c    = '0;
            upd_prio_c = 1'b0;
        end
    end

    assign fwd_c = |grant_c;

    always_comb begin
        credits_d = credits_q;
        if (fwd_c && !bus.credit_in)
            credits_d = credits_q - CW'(1);
        else if (!fwd_c && bus.credit_in && credits_q != CW'(DEPTH))
            credits_d = credits_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            owner_q   <= '0;
            credits_q <= CW'(DEPTH);
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            credits_q <= credits_d;
        end
    end

    assign bus.grant   = grant_c;
    assign bus.forward = fwd_c;
    assign bus.locked  = (state_q == LOCKED);
    assign bus.credits = credits_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(grant_c)) else $error("grant not one-hot0: %b", grant_c);
            assert (credits_q <= CW'(DEPTH)) else $error("credits above DEPTH: %0d", credits_q);
            assert (has_credit || !fwd_c) else $error("grant issued with zero credits");
            assert (!(bus.credit_in && !fwd_c && credits_q == CW'(DEPTH)) || credits_d == credits_q)
                else $error("credit_in at DEPTH not absorbed");
        end
    end
`endif
endmodule

// File: tb/tb_router_output_scheduler.sv
// Directed bench for router_output_scheduler with hand-computed expectations.
module tb_router_output_scheduler;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    router_output_scheduler_if #(.CW(3)) bus_if ();

    router_output_scheduler #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply inputs, then move to the falling edge where outputs are sampled.
    task automatic step(input logic [3:0] r, input logic [3:0] h, input logic [3:0] t, input logic cin);
        bus_if.request   = r;
        bus_if.head      = h;
        bus_if.tail      = t;
        bus_if.credit_in = cin;
        @(negedge clk);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] r33 [5] = '{4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0001};
    logic [3:0] h33 [5] = '{4'b0101, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    logic [3:0] t33 [5] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001};
    logic [3:0] g33 [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0001};
    logic       l33 [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    initial begin
        logic [3:0] e;
        rst = 1'b1;
        step(4'b1111, 4'b1111, 4'b1111, 1'b0);
        chk("rst_grant", 32'(bus_if.grant), 32'h0);
        chk("rst_fwd", 32'(bus_if.forward), 32'h0);
        tick();
        step(4'b1111, 4'b1111, 4'b1111, 1'b0);
        tick();
        rst = 1'b0;
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("rst_locked", 32'(bus_if.locked), 32'h0);
        chk("rst_credits", 32'(bus_if.credits), 32'd4);
        tick();

        // Round-robin over four single-flit packets.
        for (int k = 0; k < 4; k++) begin
            step(4'b1111, 4'b1111, 4'b1111, 1'b1);
            e = 4'(1 << k);
            chk($sformatf("rr_%0d", k), 32'(bus_if.grant), 32'(e));
            tick();
        end
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("rr_credits", 32'(bus_if.credits), 32'd4);
        tick();

        // Demote ports 0 and 1 so port 2 outranks port 0.
        step(4'b0001, 4'b0001, 4'b0001, 1'b1);
        chk("pre_p0", 32'(bus_if.grant), 32'h1);
        tick();
        step(4'b0010, 4'b0010, 4'b0010, 1'b1);
        chk("pre_p1", 32'(bus_if.grant), 32'h2);
        tick();

        for (int k = 0; k < 5; k++) begin
            step(r33[k], h33[k], t33[k], 1'b1);
            chk($sformatf("lock_grant_%0d", k), 32'(bus_if.grant), 32'(g33[k]));
            chk($sformatf("lock_locked_%0d", k), 32'(bus_if.locked), 32'(l33[k]));
            tick();
        end

        step(4'b0100, 4'b0000, 4'b0100, 1'b0);
        chk("nohead_ignored", 32'(bus_if.grant), 32'h0);
        tick();

        // Credit starvation with a 6-flit packet from port 1.
        step(4'b0010, 4'b0010, 4'b0000, 1'b0);
        chk("cr_f1", 32'(bus_if.grant), 32'h2);
        tick();
        for (int k = 0; k < 3; k++) begin
            step(4'b0010, 4'b0000, 4'b0000, 1'b0);
            chk($sformatf("cr_f%0d", k + 2), 32'(bus_if.grant), 32'h2);
            chk($sformatf("cr_c%0d", k + 2), 32'(bus_if.credits), 32'(3 - k));
            tick();
        end
        step(4'b0010, 4'b0000, 4'b0000, 1'b0);
        chk("cr_stall_grant", 32'(bus_if.grant), 32'h0);
        chk("cr_stall_credits", 32'(bus_if.credits), 32'd0);
        chk("cr_stall_locked", 32'(bus_if.locked), 32'h1);
        tick();
        step(4'b0010, 4'b0000, 4'b0000, 1'b1);
        chk("cr_ret_grant", 32'(bus_if.grant), 32'h0);
        tick();
        step(4'b0010, 4'b0000, 4'b0000, 1'b1);
        chk("cr_f5", 32'(bus_if.grant), 32'h2);
        chk("cr_f5_credits", 32'(bus_if.credits), 32'd1);
        tick();
        step(4'b0010, 4'b0000, 4'b0010, 1'b1);
        chk("cr_tail", 32'(bus_if.grant), 32'h2);
        tick();
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("cr_unlock", 32'(bus_if.locked), 32'h0);
        chk("cr_after", 32'(bus_if.credits), 32'd1);
        tick();
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 4'b0000, 4'b0000, 1'b1);
            tick();
        end

        // Simultaneous forward and credit return, then saturation.
        step(4'b1000, 4'b1000, 4'b1000, 1'b0);
        chk("sat_refill", 32'(bus_if.credits), 32'd4);
        tick();
        step(4'b1000, 4'b1000, 4'b1000, 1'b0);
        tick();
        step(4'b1000, 4'b1000, 4'b1000, 1'b1);
        chk("both_pre", 32'(bus_if.credits), 32'd2);
        chk("both_grant", 32'(bus_if.grant), 32'h8);
        tick();
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("both_post", 32'(bus_if.credits), 32'd2);
        tick();
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);
        tick();
        step(4'b0000, 4'b0000, 4'b0000, 1'b1);
        chk("sat_at4", 32'(bus_if.credits), 32'd4);
        tick();
        step(4'b0000, 4'b0000, 4'b0000, 1'b0);
        chk("sat_hold", 32'(bus_if.credits), 32'd4);
        tick();

        // Reset mid-packet; port 3 outranks port 0 beforehand.
        step(4'b0001, 4'b0001, 4'b0001, 1'b1);
        chk("mid_p0", 32'(bus_if.grant), 32'h1);
        tick();
        step(4'b0100, 4'b0100, 4'b0000, 1'b0);
        chk("mid_head", 32'(bus_if.grant), 32'h4);
        tick();
        step(4'b0100, 4'b0000, 4'b0000, 1'b0);
        chk("mid_locked", 32'(bus_if.locked), 32'h1);
        tick();
        rst = 1'b1;
        step(4'b1001, 4'b1001, 4'b1001, 1'b0);
        chk("mid_rst_grant", 32'(bus_if.grant), 32'h0);
        chk("mid_rst_fwd", 32'(bus_if.forward), 32'h0);
        tick();
        rst = 1'b0;
        step(4'b1001, 4'b1001, 4'b1001, 1'b0);
        chk("post_rst_locked", 32'(bus_if.locked), 32'h0);
        chk("post_rst_credits", 32'(bus_if.credits), 32'd4);
        chk("post_rst_grant", 32'(bus_if.grant), 32'h1);
        chk("post_rst_fwd", 32'(bus_if.forward), 32'h1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
